climate_ctrl: RTL and testbench

Parametrised climate controller for the incubator: samples a signed temperature sensor and drives heater/cooler through a hysteresis FSM with a minimum-dwell interlock. It also drives a 4-bit fan speed (crs) that ramps toward a state- and temperature-dependent target, and raises a debounced over/under-range alarm. It is the next-generation replacement for the AC + Fan pair under the incubator top level.

---
 rtl/climate_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_climate_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/climate_ctrl.sv
// climate_ctrl: incubator climate controller.
// Samples a signed temperature sensor, runs a heat/idle/cool hysteresis FSM
// with a minimum-dwell interlock, ramps a 0..8 fan speed toward a
// state-dependent target, and raises a debounced out-of-range alarm.
module climate_ctrl #(
   parameter int W         = 8,
   parameter int HEAT_ON   = 15,
   parameter int HEAT_OFF  = 28,
   parameter int COOL_OFF  = 30,
   parameter int COOL_ON   = 35,
   parameter int FAN_STEP  = 5,
   parameter int FAN_HEAT  = 2,
   parameter int RAMP_DIV  = 4,
   parameter int MIN_DWELL = 4,
   parameter int ALARM_LO  = 0,
   parameter int ALARM_HI  = 50,
   parameter int ALARM_CNT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [W-1:0] sensor,
   output logic                heater,
   output logic                cooler,
   output logic [3:0]          crs,
   output logic                alarm,
   output logic [1:0]          state
);

   // Two guard bits so COOL_ON + 2*FAN_STEP stays representable.
   localparam int CW = W + 2;
   localparam int DW = $clog2(MIN_DWELL + 1);
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int AW = (ALARM_CNT > 1) ? $clog2(ALARM_CNT + 1) : 1;

   typedef logic signed [CW-1:0] wide_t;

   localparam wide_t T_HEAT_ON  = wide_t'(HEAT_ON);
   localparam wide_t T_HEAT_OFF = wide_t'(HEAT_OFF);
   localparam wide_t T_COOL_OFF = wide_t'(COOL_OFF);
   localparam wide_t T_COOL_ON  = wide_t'(COOL_ON);
   localparam wide_t T_BAND1    = wide_t'(COOL_ON + FAN_STEP);
   localparam wide_t T_BAND2    = wide_t'(COOL_ON + 2 * FAN_STEP);
   localparam wide_t T_ALARM_LO = wide_t'(ALARM_LO);
   localparam wide_t T_ALARM_HI = wide_t'(ALARM_HI);

   localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
   localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CNT - 1);
   localparam logic [3:0]    FAN_HEAT_V = 4'(FAN_HEAT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAT = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   logic signed [W-1:0] s_q_reg;
   logic                s_v_reg;
   state_t              state_reg;
   logic                heater_reg;
   logic                cooler_reg;
   logic [DW-1:0]       dwell_reg;
   logic [RW-1:0]       ramp_cnt_reg;
   logic [3:0]          crs_reg;
   logic                alarm_reg;
   logic [AW-1:0]       alarm_cnt_reg;

   wide_t               s_ext;
   logic                lt_heat_on;
   logic                gt_heat_off;
   logic                lt_cool_off;
   logic                gt_cool_on;
   logic                dwell_ok;
   logic                ramp_wrap;
   logic                out_of_range;
   logic                alarm_hit;
   logic [3:0]          fan_target;

   assign s_ext        = {{2{s_q_reg[W-1]}}, s_q_reg};
   assign lt_heat_on   = s_ext < T_HEAT_ON;
   assign gt_heat_off  = s_ext > T_HEAT_OFF;
   assign lt_cool_off  = s_ext < T_COOL_OFF;
   assign gt_cool_on   = s_ext > T_COOL_ON;
   assign dwell_ok     = dwell_reg >= DWELL_MAX;
   assign ramp_wrap    = ramp_cnt_reg == RAMP_LAST;
   assign out_of_range = (s_ext < T_ALARM_LO) || (s_ext > T_ALARM_HI);
   // While clear, count out-of-range samples; while set, count in-range ones.
   assign alarm_hit    = alarm_reg ? !out_of_range : out_of_range;

   // Input register and valid flag (valid once the first post-reset sample lands).
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q_reg <= '0;
         s_v_reg <= 1'b0;
      end else begin
         s_q_reg <= sensor;
         s_v_reg <= 1'b1;
      end
   end

   // Hysteresis FSM with dwell interlock; heater/cooler registered with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         heater_reg <= 1'b0;
         cooler_reg <= 1'b0;
         dwell_reg  <= DWELL_MAX;
      end else begin
         if (!dwell_ok) begin
            dwell_reg <= dwell_reg + 1'b1;
         end
         if (s_v_reg && dwell_ok) begin
            case (state_reg)
               ST_IDLE: begin
                  if (lt_heat_on) begin
                     state_reg  <= ST_HEAT;
                     heater_reg <= 1'b1;
                     cooler_reg <= 1'b0;
                     dwell_reg  <= '0;
                  end else if (gt_cool_on) begin
                     state_reg  <= ST_COOL;
                     heater_reg <= 1'b0;
                     cooler_reg <= 1'b1;
                     dwell_reg  <= '0;
                  end
               end
               ST_HEAT: begin
                  if (gt_heat_off) begin
                     state_reg  <= ST_IDLE;
                     heater_reg <= 1'b0;
                     cooler_reg <= 1'b0;
                     dwell_reg  <= '0;
                  end
               end
               ST_COOL: begin
                  if (lt_cool_off) begin
                     state_reg  <= ST_IDLE;
                     heater_reg <= 1'b0;
                     cooler_reg <= 1'b0;
                     dwell_reg  <= '0;
                  end
               end
               default: begin
                  state_reg  <= ST_IDLE;
                  heater_reg <= 1'b0;
                  cooler_reg <= 1'b0;
                  dwell_reg  <= '0;
               end
            endcase
         end
      end
   end

   // Fan target from the current state and, when cooling, the temperature band.
   always_comb begin
      fan_target = 4'd0;
      case (state_reg)
         ST_HEAT: fan_target = FAN_HEAT_V;
         ST_COOL: begin
            if (s_ext <= T_BAND1) begin
               fan_target = 4'd4;
            end else if (s_ext <= T_BAND2) begin
               fan_target = 4'd6;
            end else begin
               fan_target = 4'd8;
            end
         end
         default: fan_target = 4'd0;
      endcase
   end

   // Fan ramp: one step toward the target on each ramp counter wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         ramp_cnt_reg <= '0;
         crs_reg      <= 4'd0;
      end else begin
         ramp_cnt_reg <= ramp_wrap ? '0 : ramp_cnt_reg + 1'b1;
         if (ramp_wrap && s_v_reg) begin
            if (crs_reg < fan_target) begin
               crs_reg <= crs_reg + 4'd1;
            end else if (crs_reg > fan_target) begin
               crs_reg <= crs_reg - 4'd1;
            end
         end
      end
   end

   // Alarm debounce: ALARM_CNT consecutive qualifying samples toggle the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_reg     <= 1'b0;
         alarm_cnt_reg <= '0;
      end else if (s_v_reg) begin
         if (alarm_hit) begin
            if (alarm_cnt_reg == ALARM_LAST) begin
               alarm_reg     <= !alarm_reg;
               alarm_cnt_reg <= '0;
            end else begin
               alarm_cnt_reg <= alarm_cnt_reg + 1'b1;
            end
         end else begin
            alarm_cnt_reg <= '0;
         end
      end
   end

   assign heater = heater_reg;
   assign cooler = cooler_reg;
   assign crs    = crs_reg;
   assign alarm  = alarm_reg;
   assign state  = state_reg;

endmodule

// File: tb/tb_climate_ctrl.sv
// tb_climate_ctrl: directed test of climate_ctrl with hand-computed values.
// Edge numbers in comments count rising edges since the last reset edge;
// the fan ramp wraps on every edge whose number is a multiple of 4.
module tb_climate_ctrl;

   logic              clk;
   logic              rst;
   logic signed [7:0] sensor;
   logic              heater;
   logic              cooler;
   logic [3:0]        crs;
   logic              alarm;
   logic [1:0]        state;

   int checks = 0;
   int errors = 0;
   int ecnt   = 0;

   climate_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .sensor (sensor),
      .heater (heater),
      .cooler (cooler),
      .crs    (crs),
      .alarm  (alarm),
      .state  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, ecnt);
      end
      $display("check %-14s edge=%0d observed=%0d expected=%0d", tag, ecnt, obs, exp);
   endtask

   // Advance to edge k, then settle 1 time unit past it.
   task automatic to_edge(input int k);
      while (ecnt < k) begin
         @(posedge clk);
         ecnt++;
      end
      #1;
   endtask

   initial begin
      int n;
      rst    = 1'b1;
      sensor = 8'sd22;
      repeat (2) @(posedge clk);
      #1;
      ecnt = 0;
      chk("rst_heater", heater, 0);
      chk("rst_cooler", cooler, 0);
      chk("rst_crs",    crs,    0);
      chk("rst_alarm",  alarm,  0);
      chk("rst_state",  state,  0);

      // Heat entry: 2-edge latency, fan ramps to FAN_HEAT.
      rst    = 1'b0;
      sensor = 8'sd10;
      to_edge(1);  chk("heat_lat1", heater, 0);
      to_edge(2);  chk("heat_on", heater, 1); chk("heat_state", state, 1); chk("heat_nocool", cooler, 0);
      to_edge(3);  chk("crs_e3", crs, 0);
      to_edge(4);  chk("crs_e4", crs, 1);
      to_edge(7);  chk("crs_e7", crs, 1);
      to_edge(8);  chk("crs_e8", crs, 2);
      to_edge(12); chk("crs_hold2", crs, 2);

      // Hysteresis inside HEAT, then exit above HEAT_OFF.
      sensor = 8'sd20;
      to_edge(15); chk("hyst_hold", heater, 1);
      sensor = 8'sd29;
      to_edge(16); chk("heat_off_lat", heater, 1);
      to_edge(17); chk("heat_off", heater, 0); chk("idle_state", state, 0);
      sensor = 8'sd22;
      to_edge(20); chk("crs_dn1", crs, 1);
      to_edge(24); chk("crs_dn0", crs, 0);

      // Cool entry and fan bands.
      sensor = 8'sd36;
      to_edge(25); chk("cool_lat1", cooler, 0);
      to_edge(26); chk("cool_on", cooler, 1); chk("cool_state", state, 2); chk("cool_noheat", heater, 0);
      to_edge(28); chk("cool_crs1", crs, 1);
      to_edge(40); chk("band36_crs", crs, 4);
      to_edge(44); chk("band36_hold", crs, 4);
      sensor = 8'sd41;
      to_edge(48); chk("band41_e48", crs, 5);
      to_edge(52); chk("band41_crs", crs, 6);
      to_edge(56); chk("band41_hold", crs, 6);
      sensor = 8'sd46;
      to_edge(60); chk("band46_e60", crs, 7);
      to_edge(64); chk("band46_crs", crs, 8);
      to_edge(68); chk("band46_hold", crs, 8);
      sensor = 8'sd37;
      to_edge(72); chk("down_e72", crs, 7);
      to_edge(75); chk("down_e75", crs, 7);
      to_edge(76); chk("down_e76", crs, 6);
      to_edge(80); chk("down_e80", crs, 5);
      to_edge(84); chk("down_e84", crs, 4);
      to_edge(88); chk("down_hold4", crs, 4);

      // Leave COOL below COOL_OFF.
      sensor = 8'sd20;
      to_edge(89); chk("cool_off_lat", cooler, 1);
      to_edge(90); chk("cool_off", cooler, 0); chk("idle_state2", state, 0);

      // Dwell on HEAT entry: one cold sample, then too warm.
      to_edge(94);
      sensor = 8'sd10;
      to_edge(95);
      sensor = 8'sd29;
      to_edge(96);  chk("dwell_h_on", heater, 1);
      to_edge(100); chk("dwell_h_hold", heater, 1);
      to_edge(101); chk("dwell_h_off", heater, 0); chk("dwell_h_st", state, 0);

      // Dwell on COOL entry: one hot sample, then cool.
      to_edge(105);
      sensor = 8'sd40;
      to_edge(106);
      sensor = 8'sd20;
      to_edge(107); chk("dwell_c_on", cooler, 1); chk("dwell_c_st", state, 2);
      to_edge(111); chk("dwell_c_hold", cooler, 1);
      to_edge(112); chk("dwell_c_off", cooler, 0);

      // Alarm debounce.
      sensor = -8'sd5;
      to_edge(119);
      sensor = 8'sd10;
      to_edge(121); chk("alarm_7lo", alarm, 0);
      to_edge(125); chk("alarm_7lo_b", alarm, 0);
      sensor = -8'sd5;
      to_edge(133); chk("alarm_pre_set", alarm, 0);
      sensor = 8'sd20;
      to_edge(134); chk("alarm_set", alarm, 1);
      to_edge(140);
      sensor = 8'sd60;
      to_edge(141); chk("alarm_7in", alarm, 1);
      to_edge(145); chk("alarm_7in_b", alarm, 1);
      sensor = 8'sd20;
      to_edge(153); chk("alarm_pre_clr", alarm, 1);
      to_edge(154); chk("alarm_clr", alarm, 0);

      // Reach COOL with crs=6, then reset mid-operation.
      sensor = 8'sd41;
      n = 0;
      while (!(cooler === 1'b1 && crs === 4'd6) && n < 200) begin
         to_edge(ecnt + 1);
         n++;
      end
      chk("reach_cool6", {27'd0, cooler, crs}, {27'd0, 1'b1, 4'd6});
      rst = 1'b1;
      @(posedge clk);
      #1;
      ecnt = 0;
      chk("mid_rst_heater", heater, 0);
      chk("mid_rst_cooler", cooler, 0);
      chk("mid_rst_crs",    crs,    0);
      chk("mid_rst_alarm",  alarm,  0);
      chk("mid_rst_state",  state,  0);
      rst    = 1'b0;
      sensor = 8'sd40;
      to_edge(1); chk("sv_gate", cooler, 0);
      to_edge(2); chk("sv_cool_on", cooler, 1); chk("sv_cool_st", state, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
